niosv_reset_sequencer: RTL

NIOSV_RESET_SEQUENCER -- requirements
Module: niosv_reset_sequencer

---
 rtl/niosv_rstseq_pkg.sv | 21 ++
 rtl/rstseq_debounce.sv | 42 ++++
 rtl/niosv_reset_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/niosv_rstseq_pkg.sv
// Shared types and constants for the Nios V reset sequencer: FSM state encoding,
// reset-cause codes and the saturating episode counter helper.
package niosv_rstseq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_BTN = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == COUNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rstseq_debounce.sv
// Two-flop synchronizer plus level debouncer for the active-low user button.
// btn_db only follows btn_s after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module rstseq_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          btn_s;
    logic [CW-1:0] mismatch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1      <= 1'b1;
            btn_s        <= 1'b1;
            mismatch_cnt <= '0;
            btn_db       <= 1'b1;
        end else begin
            sync_q1 <= btn_n;
            btn_s   <= sync_q1;
            // A single cycle of agreement restarts the stability window.
            if (btn_s != btn_db) begin
                if (mismatch_cnt == CNT_LAST) begin
                    btn_db       <= btn_s;
                    mismatch_cnt <= '0;
                end else begin
                    mismatch_cnt <= mismatch_cnt + CW'(1);
                end
            end else begin
                mismatch_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/niosv_reset_sequencer.sv
// Reset sequencer for the Nios V system: debounced button, minimum hold time and
// optional software watchdog (enabled by defining RSTSEQ_WDOG_EN).
module niosv_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 256,
    parameter int WDOG_CYCLES     = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       wdog_kick,
    output logic       sys_reset_n,
    output logic       run,
    output logic [1:0] rst_cause,
    output logic [7:0] reset_count
);

    import niosv_rstseq_pkg::*;

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    logic [HW-1:0] hold_cnt;
    logic          btn_db;
    logic          wdog_timeout;
    logic          trip;
    logic [1:0]    trip_cause;

    rstseq_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_n),
        .btn_db(btn_db)
    );

`ifdef RSTSEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (reset || (state != ST_RUN) || wdog_kick) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end
    end

    // A kick landing on the terminal count suppresses the timeout.
    assign wdog_timeout = (state == ST_RUN) && (wdog_cnt == WDOG_LAST) && !wdog_kick;
`else
    logic unused_wdog_kick;

    assign unused_wdog_kick = wdog_kick;
    assign wdog_timeout     = 1'b0;
`endif

    always_comb begin
        next_state = state;
        trip       = 1'b0;
        trip_cause = CAUSE_POR;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    next_state = ST_WAIT_BTN;
                end
            end
            ST_WAIT_BTN: begin
                if (btn_db) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Button outranks a coincident watchdog timeout.
                if (!btn_db) begin
                    next_state = ST_HOLD;
                    trip       = 1'b1;
                    trip_cause = CAUSE_BTN;
                end else if (wdog_timeout) begin
                    next_state = ST_HOLD;
                    trip       = 1'b1;
                    trip_cause = CAUSE_WDOG;
                end
            end
            default: begin
                next_state = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            sys_reset_n <= 1'b0;
            run         <= 1'b0;
            rst_cause   <= CAUSE_POR;
            reset_count <= '0;
        end else begin
            state <= next_state;
            if ((state == ST_HOLD) && (next_state == ST_HOLD)) begin
                hold_cnt <= hold_cnt + HW'(1);
            end else begin
                hold_cnt <= '0;
            end
            // Outputs are registered from next_state so they align with state.
            sys_reset_n <= (next_state == ST_RUN);
            run         <= (next_state == ST_RUN);
            if (trip) begin
                rst_cause   <= trip_cause;
                reset_count <= sat_inc8(reset_count);
            end
        end
    end

endmodule
